// File: rtl/serial_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_scheduler_pkg
// Desc     : Shared state encodings and sizing helpers for the serial blocks
// Revision : 1.0 - initial release
// ============================================================================
package serial_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Register widths must never collapse to zero bits
  function automatic int clog2_min1(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_scheduler_if
// Desc     : Requester-side and serial-side signals of the scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface serial_tx_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 24
);
  import serial_tx_scheduler_pkg::*;

  localparam int c_idw = clog2_min1(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       ack;
  logic [c_idw-1:0]      cur_id;
  logic                  serial_out;
  logic                  frame;
  logic                  done;
  logic                  busy;

  modport master (
    output req, data,
    input  ack, cur_id, serial_out, frame, done, busy
  );

  modport slave (
    input  req, data,
    output ack, cur_id, serial_out, frame, done, busy
  );

endinterface
`default_nettype wire

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_scheduler_rr_arbiter
// Desc     : Combinational round-robin pick, searching upward from last_grant+1
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_scheduler_rr_arbiter
  import serial_tx_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            valid
);

  logic [IDW-1:0] w_idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    valid    = 1'b0;
    w_idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = IDW'((int'(last_grant) + i) % NREQ);
      if (!valid && req[w_idx]) begin
        valid        = 1'b1;
        grant_id     = w_idx;
        grant[w_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_scheduler
// Desc     : Round-robin capture of one requester word, shifted out MSB first
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_scheduler
  import serial_tx_scheduler_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 24,
  parameter int GAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_tx_scheduler_if.slave bus
);

  localparam int c_idw      = clog2_min1(NREQ);
  localparam int c_cw       = clog2_min1(WIDTH);
  localparam int c_gw       = clog2_min1(GAP);
  localparam int c_gap_init = (GAP > 0) ? GAP - 1 : 0;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [c_cw-1:0]    r_bitcnt;
  logic [c_gw-1:0]    r_gapcnt;
  logic [c_idw-1:0]   r_last_grant, r_cur_id, w_win_id;
  logic [NREQ-1:0]    r_ack, w_grant;
  logic               r_serial, r_frame, r_done, r_busy;
  logic               w_valid, w_load, w_shift, w_finish;
  logic [WIDTH-1:0]   w_words [NREQ];
  logic [WIDTH-1:0]   w_word;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign w_words[k] = bus.data[k*WIDTH +: WIDTH];
  end

  assign w_word = w_words[w_win_id];

  serial_tx_scheduler_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (c_idw)
  ) u_arb (
    .req        (bus.req),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_id   (w_win_id),
    .valid      (w_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_bitcnt == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          w_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gapcnt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The MSB leaves on the capture edge itself, so r_shift holds only the bits still to go
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_gapcnt     <= '0;
      r_last_grant <= c_idw'(NREQ - 1);
      r_cur_id     <= '0;
      r_ack        <= '0;
      r_serial     <= 1'b0;
      r_frame      <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_done <= 1'b0;
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_load) begin
        r_shift      <= {w_word[WIDTH-2:0], 1'b0};
        r_serial     <= w_word[WIDTH-1];
        r_frame      <= 1'b1;
        r_bitcnt     <= c_cw'(WIDTH - 1);
        r_cur_id     <= w_win_id;
        r_last_grant <= w_win_id;
        r_ack        <= w_grant;
      end
      if (w_shift) begin
        r_serial <= r_shift[WIDTH-1];
        r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
        r_bitcnt <= r_bitcnt - 1'b1;
      end
      if (w_finish) begin
        r_serial <= 1'b0;
        r_frame  <= 1'b0;
        r_done   <= 1'b1;
        r_gapcnt <= c_gw'(c_gap_init);
      end
      if (r_state == ST_GAP && r_gapcnt != '0) r_gapcnt <= r_gapcnt - 1'b1;
    end
  end

  assign bus.ack        = r_ack;
  assign bus.cur_id     = r_cur_id;
  assign bus.serial_out = r_serial;
  assign bus.frame      = r_frame;
  assign bus.done       = r_done;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_scheduler
// Desc     : Self-checking bench for the round-robin serial scheduler
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 24;

  typedef struct {
    bit          do_reset;
    logic [3:0]  add;
    logic [23:0] word;
    int          exp_id;
  } vec_t;

  typedef struct {
    int          id;
    logic [23:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_tx_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus   ();
  serial_tx_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) gbus0 ();
  serial_tx_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) gbus3 ();

  serial_tx_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(1)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave));
  serial_tx_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(0)) dut_g0 (
    .clk (clk), .rst (rst), .bus (gbus0.slave));
  serial_tx_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(3)) dut_g3 (
    .clk (clk), .rst (rst), .bus (gbus3.slave));

  // Spacing instances see permanently held requests, so words go out back to back
  assign gbus0.req  = 4'b0011;
  assign gbus0.data = {24'h0, 24'h0, 24'h5A5A5A, 24'hC3C3C3};
  assign gbus3.req  = 4'b0011;
  assign gbus3.data = {24'h0, 24'h0, 24'h5A5A5A, 24'hC3C3C3};

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];
  vec_t        vt[13];
  logic [3:0]  pending;
  logic [23:0] words[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.req = pending;
    for (int k = 0; k < NREQ; k++) bus.data[k*WIDTH +: WIDTH] = words[k];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 4'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_ack",    32'(bus.ack),        0);
    chk("rst_cur_id", 32'(bus.cur_id),     0);
    chk("rst_serial", 32'(bus.serial_out), 0);
    chk("rst_frame",  32'(bus.frame),      0);
    chk("rst_done",   32'(bus.done),       0);
    chk("rst_busy",   32'(bus.busy),       0);
    pending = '0;
    drive();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int exp_id);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.ack == '0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ack",    32'(bus.ack),    32'(1 << exp_id));
    chk("cur_id", 32'(bus.cur_id), 32'(exp_id));
    chk("busy",   32'(bus.busy),   1);
    pending[exp_id] = 1'b0;
    drive();
    @(negedge clk);
    chk("ack_pulse", 32'(bus.ack), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    if (v.do_reset) do_reset();
    for (int k = 0; k < NREQ; k++) begin
      if (v.add[k]) begin
        pending[k] = 1'b1;
        words[k]   = v.word ^ 24'(k * 'h010203);
      end
    end
    drive();
    sb.push_back('{v.exp_id, words[v.exp_id]});
    wait_ack(v.exp_id);
    t = 0;
    while (!bus.done && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(bus.done), 1);
  endtask

  // Serial monitor: rebuilds each word from frame/serial_out and checks it on done
  int          mcnt = 0;
  logic [23:0] mword = '0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.frame) begin
      mword = {mword[22:0], bus.serial_out};
      mcnt++;
    end else if (bus.done) begin
      chk("frame_len", 32'(mcnt), 32'(WIDTH));
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        chk("word",    32'(mword),      32'(e.word));
        chk("done_id", 32'(bus.cur_id), 32'(e.id));
      end
      mcnt = 0;
    end else begin
      mcnt = 0;
    end
  end

  // Idle-run measurement between consecutive frames of the spacing instances
  bit gap_meas = 1'b0;
  int runs0[2], runs3[2];
  int nruns0 = 0, nruns3 = 0, low0 = 0, low3 = 0;
  bit seen0 = 1'b0, seen3 = 1'b0;
  always @(negedge clk) begin
    if (!gap_meas) begin
      seen0 = 1'b0; low0 = 0; nruns0 = 0;
      seen3 = 1'b0; low3 = 0; nruns3 = 0;
    end else begin
      if (gbus0.frame) begin
        if (seen0 && low0 > 0) begin
          if (nruns0 < 2) runs0[nruns0] = low0;
          nruns0++;
        end
        seen0 = 1'b1; low0 = 0;
      end else if (seen0) low0++;
      if (gbus3.frame) begin
        if (seen3 && low3 > 0) begin
          if (nruns3 < 2) runs3[nruns3] = low3;
          nruns3++;
        end
        seen3 = 1'b1; low3 = 0;
      end else if (seen3) low3++;
    end
  end

  initial begin
    int t;
    int bits;
    bus.req  = '0;
    bus.data = '0;
    pending  = '0;
    for (int k = 0; k < NREQ; k++) words[k] = '0;

    vt[0]  = '{1'b1, 4'b0001, 24'hA5F00F, 0};
    vt[1]  = '{1'b1, 4'b1111, 24'h123456, 0};
    vt[2]  = '{1'b0, 4'b0000, 24'h000000, 1};
    vt[3]  = '{1'b0, 4'b0000, 24'h000000, 2};
    vt[4]  = '{1'b0, 4'b0001, 24'h0F1E2D, 3};
    vt[5]  = '{1'b0, 4'b0000, 24'h000000, 0};
    vt[6]  = '{1'b1, 4'b0100, 24'h800001, 2};
    vt[7]  = '{1'b0, 4'b0101, 24'h5AA55A, 0};
    vt[8]  = '{1'b0, 4'b0000, 24'h000000, 2};
    vt[9]  = '{1'b0, 4'b1010, 24'hFFFFFF, 3};
    vt[10] = '{1'b0, 4'b0000, 24'h000000, 1};
    vt[11] = '{1'b0, 4'b1001, 24'h00C0DE, 0};
    vt[12] = '{1'b0, 4'b0000, 24'h000000, 3};

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // Reset lands mid-frame: the word is abandoned without done and never re-acked
    do_reset();
    pending  = 4'b0001;
    words[0] = 24'hFEDCBA;
    drive();
    sb.push_back('{0, words[0]});
    wait_ack(0);
    bits = 1;
    t    = 0;
    while (bits < 10 && t < 100) begin
      @(negedge clk);
      if (bus.frame) bits++;
      t++;
    end
    chk("abort_bits", 32'(bits), 10);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_frame", 32'(bus.frame), 0);
    chk("abort_done",  32'(bus.done),  0);
    chk("abort_busy",  32'(bus.busy),  0);
    chk("abort_ack",   32'(bus.ack),   0);
    @(negedge clk);
    chk("abort_done2", 32'(bus.done),  0);
    rst = 1'b0;
    sb.delete();

    for (int i = 11; i < 13; i++) run_vec(vt[i]);

    gap_meas = 1'b1;
    repeat (150) @(negedge clk);
    chk("g0_nruns", 32'(nruns0 >= 2), 1);
    chk("g0_gap_a", 32'(runs0[0]),    1);
    chk("g0_gap_b", 32'(runs0[1]),    1);
    chk("g3_nruns", 32'(nruns3 >= 2), 1);
    chk("g3_gap_a", 32'(runs3[0]),    4);
    chk("g3_gap_b", 32'(runs3[1]),    4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
